reg_bank: RTL and testbench

- Parametrised successor to the single-purpose enable registers in the processor datapath.
- Holds NREGS general registers of WIDTH bits, with one write port and two read ports.
- The top register doubles as the program counter, with an auto-increment mode.
- Includes a separate instruction register of IR_WIDTH bits.
- Read ports are registered: one-cycle latency, with optional write-to-read bypass.
- Replaces per-register instances in the datapath; adds asynchronous reset to known zero state.

---
 rtl/reg_bank.sv | 105 ++++++++++
 tb/tb_reg_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: parametrised general register file with one write port, two
// registered read ports, a program counter in the top register and a
// separate instruction register.
//
// Ports:
//   Clock            rising-edge clock for all state
//   Resetn           asynchronous active-low reset, clears all state to 0
//   we/waddr/wdata   general register write port
//   re               read enable; rdata_a/rdata_b hold while low
//   raddr_a/raddr_b  read port addresses
//   rdata_a/rdata_b  registered read data, one cycle after the address
//   pc_incr          add PC_STEP to register NREGS-1
//   pc               current contents of register NREGS-1
//   ir_load/ir_in    instruction register load strobe and data
//   ir               instruction register contents
module reg_bank #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned NREGS    = 8,
   parameter int unsigned IR_WIDTH = 9,
   parameter bit          BYPASS   = 1'b1,
   parameter int unsigned PC_STEP  = 1
) (
   input  logic                       Clock,
   input  logic                       Resetn,
   input  logic                       we,
   input  logic [$clog2(NREGS)-1:0]   waddr,
   input  logic [WIDTH-1:0]           wdata,
   input  logic [$clog2(NREGS)-1:0]   raddr_a,
   input  logic [$clog2(NREGS)-1:0]   raddr_b,
   input  logic                       re,
   output logic [WIDTH-1:0]           rdata_a,
   output logic [WIDTH-1:0]           rdata_b,
   input  logic                       pc_incr,
   output logic [WIDTH-1:0]           pc,
   input  logic                       ir_load,
   input  logic [IR_WIDTH-1:0]        ir_in,
   output logic [IR_WIDTH-1:0]        ir
);

   localparam int unsigned AW = $clog2(NREGS);
   localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

   logic [WIDTH-1:0]    regs_q [NREGS];
   logic [WIDTH-1:0]    regs_d [NREGS];
   logic [WIDTH-1:0]    rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0]    rdata_b_q, rdata_b_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;

   // Next register state: PC increment first so an explicit write to the PC wins.
   always_comb begin
      regs_d = regs_q;
      if (pc_incr) begin
         regs_d[PC_IDX] = regs_q[PC_IDX] + WIDTH'(PC_STEP);
      end
      if (we) begin
         regs_d[waddr] = wdata;
      end
   end

   // Read ports: with bypass, read the post-edge value (covers writes and PC increment).
   always_comb begin
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      if (re) begin
         if (BYPASS) begin
            rdata_a_d = regs_d[raddr_a];
            rdata_b_d = regs_d[raddr_b];
         end else begin
            rdata_a_d = regs_q[raddr_a];
            rdata_b_d = regs_q[raddr_b];
         end
      end
   end

   // Instruction register next state.
   always_comb begin
      ir_d = ir_q;
      if (ir_load) begin
         ir_d = ir_in;
      end
   end

   // State registers.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         ir_q      <= '0;
      end else begin
         regs_q    <= regs_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
         ir_q      <= ir_d;
      end
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;
   assign pc      = regs_q[PC_IDX];
   assign ir      = ir_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed self-checking bench for reg_bank. Three instances:
// default (bypass), a BYPASS=0 copy sharing its stimulus, and a 32-bit x 16
// register instance.
module tb_reg_bank;

   logic        Clock;
   logic        Resetn;
   logic        we, re, pc_incr, ir_load;
   logic [2:0]  waddr, raddr_a, raddr_b;
   logic [15:0] wdata;
   logic [8:0]  ir_in;

   logic [15:0] a0, b0, pc0, a1, b1, pc1;
   logic [8:0]  ir0, ir1;

   logic        w_we, w_re, w_pc_incr, w_ir_load;
   logic [3:0]  w_waddr, w_raddr_a, w_raddr_b;
   logic [31:0] w_wdata, w_a, w_b, w_pc;
   logic [8:0]  w_ir_in, w_ir;

   int n_cmp = 0;
   int n_err = 0;

   reg_bank u_dut (
      .Clock(Clock), .Resetn(Resetn), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .re(re), .rdata_a(a0), .rdata_b(b0),
      .pc_incr(pc_incr), .pc(pc0), .ir_load(ir_load), .ir_in(ir_in), .ir(ir0)
   );

   reg_bank #(.BYPASS(1'b0)) u_dut_nb (
      .Clock(Clock), .Resetn(Resetn), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .re(re), .rdata_a(a1), .rdata_b(b1),
      .pc_incr(pc_incr), .pc(pc1), .ir_load(ir_load), .ir_in(ir_in), .ir(ir1)
   );

   reg_bank #(.WIDTH(32), .NREGS(16)) u_dut_w (
      .Clock(Clock), .Resetn(Resetn), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
      .raddr_a(w_raddr_a), .raddr_b(w_raddr_b), .re(w_re), .rdata_a(w_a), .rdata_b(w_b),
      .pc_incr(w_pc_incr), .pc(w_pc), .ir_load(w_ir_load), .ir_in(w_ir_in), .ir(w_ir)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [31:0] pat(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'hA500_3C00;
   endfunction

   initial begin
      Resetn = 1'b0;
      we = 0; re = 0; pc_incr = 0; ir_load = 0;
      waddr = '0; raddr_a = '0; raddr_b = '0; wdata = '0; ir_in = '0;
      w_we = 0; w_re = 0; w_pc_incr = 0; w_ir_load = 0;
      w_waddr = '0; w_raddr_a = '0; w_raddr_b = '0; w_wdata = '0; w_ir_in = '0;
      tick(); tick();
      Resetn = 1'b1;

      check("rst_rdata_a", 32'(a0), 32'h0);
      check("rst_rdata_b", 32'(b0), 32'h0);
      check("rst_pc", 32'(pc0), 32'h0);
      check("rst_ir", 32'(ir0), 32'h0);

      // Load some state, then reset asynchronously mid-cycle.
      we = 1; waddr = 3; wdata = 16'hBEEF; ir_load = 1; ir_in = 9'h0AB; pc_incr = 1;
      tick();
      we = 0; ir_load = 0; pc_incr = 0; re = 1; raddr_a = 3; raddr_b = 3;
      tick();
      check("pre_rst_rdata_a", 32'(a0), 32'h0000_BEEF);
      check("pre_rst_pc", 32'(pc0), 32'h1);
      check("pre_rst_ir", 32'(ir0), 32'h0AB);
      #2;
      Resetn = 1'b0;
      #1;
      check("async_rst_rdata_a", 32'(a0), 32'h0);
      check("async_rst_rdata_b", 32'(b0), 32'h0);
      check("async_rst_pc", 32'(pc0), 32'h0);
      check("async_rst_ir", 32'(ir0), 32'h0);
      we = 1; waddr = 3; wdata = 16'h1111; re = 0;
      tick();
      Resetn = 1'b1;
      we = 0; re = 1; raddr_a = 3; raddr_b = 3;
      tick();
      check("post_rst_r3", 32'(a0), 32'h0);

      // Write then read with one-cycle latency, then hold with re=0.
      re = 0; we = 1; waddr = 2; wdata = 16'h1234;
      tick();
      we = 0; re = 1; raddr_a = 2; raddr_b = 2;
      check("latency_before", 32'(a0), 32'h0);
      tick();
      check("wr_rd_a", 32'(a0), 32'h1234);
      check("wr_rd_b", 32'(b0), 32'h1234);
      re = 0; raddr_a = 3; raddr_b = 0; we = 1; waddr = 2; wdata = 16'h5555;
      tick();
      check("hold_a", 32'(a0), 32'h1234);
      check("hold_b", 32'(b0), 32'h1234);

      // Write-to-read bypass on one port, then on both ports.
      re = 0; we = 1; waddr = 5; wdata = 16'h0011;
      tick();
      we = 1; waddr = 5; wdata = 16'hA5A5; re = 1; raddr_a = 5; raddr_b = 2;
      tick();
      check("byp1_a", 32'(a0), 32'hA5A5);
      check("byp0_a", 32'(a1), 32'h0011);
      check("byp1_b_other", 32'(b0), 32'h5555);
      check("byp0_b_other", 32'(b1), 32'h5555);
      we = 1; waddr = 4; wdata = 16'h7777; raddr_a = 4; raddr_b = 4;
      tick();
      check("byp1_both_a", 32'(a0), 32'h7777);
      check("byp1_both_b", 32'(b0), 32'h7777);
      check("byp0_both_a", 32'(a1), 32'h0);
      check("byp0_both_b", 32'(b1), 32'h0);

      // PC increment from reset value, with bypass of the increment.
      we = 0; re = 1; raddr_a = 7; raddr_b = 7; pc_incr = 1;
      for (int i = 0; i < 4; i++) tick();
      check("pc_after4", 32'(pc0), 32'h4);
      check("pc_after4_nb", 32'(pc1), 32'h4);
      check("pc_incr_byp1", 32'(a0), 32'h4);
      check("pc_incr_byp0", 32'(a1), 32'h3);
      pc_incr = 0; we = 1; waddr = 7; wdata = 16'hFFFF;
      tick();
      check("pc_write", 32'(pc0), 32'hFFFF);
      we = 0; pc_incr = 1;
      tick();
      check("pc_wrap", 32'(pc0), 32'h0);
      we = 1; waddr = 7; wdata = 16'h0040; pc_incr = 1;
      tick();
      check("pc_conflict", 32'(pc0), 32'h0040);
      check("pc_conflict_nb", 32'(pc1), 32'h0040);
      check("pc_conflict_byp1", 32'(a0), 32'h0040);
      check("pc_conflict_byp0", 32'(a1), 32'h0);
      we = 0; pc_incr = 0;

      // Instruction register load and hold; general registers untouched.
      re = 0; ir_load = 1; ir_in = 9'h1C3;
      tick();
      check("ir_load", 32'(ir0), 32'h1C3);
      ir_load = 0; ir_in = 9'h000;
      tick();
      check("ir_hold", 32'(ir0), 32'h1C3);
      re = 1; raddr_a = 2; raddr_b = 5;
      tick();
      check("ir_regs_r2", 32'(a0), 32'h5555);
      check("ir_regs_r5", 32'(b0), 32'hA5A5);
      check("ir_regs_pc", 32'(pc0), 32'h0040);
      re = 0;

      // 32-bit x 16 instance: distinct pattern in every register, no aliasing.
      check("w_pc_rst", w_pc, 32'h0);
      w_we = 1;
      for (int i = 0; i < 16; i++) begin
         w_waddr = 4'(i); w_wdata = pat(i);
         tick();
      end
      w_we = 0; w_re = 1;
      for (int i = 0; i < 16; i++) begin
         w_raddr_a = 4'(i); w_raddr_b = 4'(15 - i);
         tick();
         check($sformatf("w_rd_a%0d", i), w_a, pat(i));
         check($sformatf("w_rd_b%0d", 15 - i), w_b, pat(15 - i));
      end
      check("w_pc_is_r15", w_pc, pat(15));
      w_re = 0; w_pc_incr = 1;
      tick();
      w_pc_incr = 0;
      check("w_pc_incr", w_pc, pat(15) + 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
